// File: rtl/crc_serial_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : crc_serial_engine_if
//  Description : Bit-stream, dump handshake and status bundle for
//                crc_serial_engine. The master side drives the serial bits
//                and dump controls; the slave side is the CRC engine.
//  Revision    : 1.0 - initial release
// ============================================================================
interface crc_serial_engine_if #(
    parameter int WIDTH = 16
);
    logic             clear;
    logic             bit_valid;
    logic             bit_in;
    logic             dump_start;
    logic             dump_ready;
    logic             crc_bit_out;
    logic             crc_bit_valid;
    logic             dump_done;
    logic             busy;
    logic [WIDTH-1:0] crc_value;
    logic             crc_ok;

    modport master (
        output clear,
        output bit_valid,
        output bit_in,
        output dump_start,
        output dump_ready,
        input  crc_bit_out,
        input  crc_bit_valid,
        input  dump_done,
        input  busy,
        input  crc_value,
        input  crc_ok
    );

    modport slave (
        input  clear,
        input  bit_valid,
        input  bit_in,
        input  dump_start,
        input  dump_ready,
        output crc_bit_out,
        output crc_bit_valid,
        output dump_done,
        output busy,
        output crc_value,
        output crc_ok
    );
endinterface
`default_nettype wire

// File: rtl/crc_serial_engine.sv
`default_nettype none
// ============================================================================
//  Module      : crc_serial_engine
//  Description : Bit-serial CRC generator/checker (MSB-first Galois LFSR).
//                Accumulates a CRC over a serial bit stream, then shifts the
//                register out MSB first under a ready/valid handshake.
//                Optional macro CRC_RESIDUAL_CHECK_EN enables the residual
//                compare driving crc_ok; otherwise crc_ok is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module crc_serial_engine #(
    parameter int               WIDTH      = 16,
    parameter logic [WIDTH-1:0] POLY       = 16'h8005,
    parameter logic [WIDTH-1:0] INIT       = '1,
    parameter bit               INVERT_OUT = 1'b1,
    parameter logic [WIDTH-1:0] RESIDUAL   = 16'h800D
) (
    input  wire                 clk,
    input  wire                 rst,
    crc_serial_engine_if.slave  bus
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DUMP  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   crc_q,   crc_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;

    logic               w_fb;
    logic [WIDTH-1:0]   w_crc_upd;

    // One LFSR step for the incoming bit; only used when a bit is absorbed.
    always_comb begin
        w_fb      = crc_q[WIDTH-1] ^ bus.bit_in;
        w_crc_upd = {crc_q[WIDTH-2:0], 1'b0} ^ (w_fb ? POLY : '0);
    end

    // Next-state logic: clear beats everything; in DUMP the handshake owns
    // the register and incoming bits / dump_start are ignored.
    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        cnt_d   = cnt_q;

        if (bus.clear) begin
            state_d = ST_IDLE;
            crc_d   = INIT;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_ACCUM: begin
                    if (bus.bit_valid) begin
                        crc_d   = w_crc_upd;
                        state_d = ST_ACCUM;
                    end
                    // A bit arriving with dump_start is absorbed first, so
                    // the dump sees the updated register.
                    if (bus.dump_start) begin
                        state_d = ST_DUMP;
                        cnt_d   = '0;
                    end
                end
                ST_DUMP: begin
                    if (bus.dump_ready) begin
                        crc_d = {crc_q[WIDTH-2:0], 1'b0};
                        if (cnt_q == CNT_LAST) begin
                            state_d = ST_DONE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d   = cnt_q + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    crc_d   = INIT;
                    cnt_d   = '0;
                end
                default: begin
                    state_d = ST_IDLE;
                    crc_d   = INIT;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, LFSR and bit-counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            crc_q   <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Status and serial output decode, all from registered state.
    always_comb begin
        bus.crc_bit_valid = (state_q == ST_DUMP);
        bus.crc_bit_out   = (state_q == ST_DUMP) ? (crc_q[WIDTH-1] ^ INVERT_OUT) : 1'b0;
        bus.dump_done     = (state_q == ST_DONE);
        bus.busy          = (state_q == ST_DUMP) || (state_q == ST_DONE);
        bus.crc_value     = crc_q;
    end

`ifdef CRC_RESIDUAL_CHECK_EN
    // Good-frame indication while the engine is accumulating.
    always_comb begin
        bus.crc_ok = ((state_q == ST_IDLE) || (state_q == ST_ACCUM)) && (crc_q == RESIDUAL);
    end
`else
    // Residual compare not built; the port is kept for a uniform footprint.
    always_comb begin
        bus.crc_ok = 1'b0;
    end
`endif

endmodule
`default_nettype wire
